// File: rtl/null_former_dbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : null_former_dbuf                                                |
// | Brief    : CRPA null-forming FIR sum with double-buffered coefficient banks|
// |            and sample-aligned swap, shift/saturate output, sat counter.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module null_former_dbuf #(
  parameter int NCH       = 4,
  parameter int NT        = 8,
  parameter int D_WIDTH   = 12,
  parameter int C_WIDTH   = 16,
  parameter int CNT_WIDTH = 16,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TAP_W    = $clog2(NT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NCH*D_WIDTH-1:0]      in_data,
  input  logic                        ce,
  input  logic                        coef_we,
  input  logic [CH_W-1:0]             coef_ch,
  input  logic [TAP_W-1:0]            coef_tap,
  input  logic signed [C_WIDTH-1:0]   coef_data,
  input  logic                        coef_swap,
  input  logic                        coef_mirr,
  input  logic [7:0]                  null_div,
  input  logic                        sat_clr,
  output logic                        out_valid,
  output logic [D_WIDTH-1:0]          out_data,
  output logic                        active_bank,
  output logic                        swap_done,
  output logic [CNT_WIDTH-1:0]        sat_cnt
);

  localparam int NPROD  = NCH * NT;
  localparam int LVL    = $clog2(NPROD);
  localparam int LEAVES = 1 << LVL;
  localparam int PROD_W = D_WIDTH + C_WIDTH;
  localparam int SUM_W  = PROD_W + LVL;

  localparam logic [7:0]             SH_MAX  = 8'(SUM_W - 1);
  localparam logic [CH_W:0]          NCH_L   = (CH_W + 1)'(NCH);
  localparam logic [TAP_W:0]         NT_L    = (TAP_W + 1)'(NT);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX = '1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  logic signed [D_WIDTH-1:0] r_dly  [NCH][NT];
  logic signed [C_WIDTH-1:0] r_coef [2][NCH][NT];
  logic signed [PROD_W-1:0]  r_prod [NPROD];
  // Pipelined heap: node i sums children 2i and 2i+1; indices >= LEAVES are the products.
  logic signed [SUM_W-1:0]   r_node [1:LEAVES-1];
  logic signed [SUM_W-1:0]   w_val  [2:2*LEAVES-1];
  logic [LVL+1:0]            r_vp;
  logic                      r_active;
  logic                      r_pend;
  logic                      r_swap_done;
  logic                      r_out_valid;
  logic [D_WIDTH-1:0]        r_out_data;
  logic [CNT_WIDTH-1:0]      r_sat_cnt;

  logic                      w_wr_ok;
  logic                      w_swap;
  logic [7:0]                w_shamt;
  logic signed [SUM_W-1:0]   w_shifted;
  logic                      w_hi;
  logic                      w_lo;
  logic [D_WIDTH-1:0]        w_sat_val;

  assign w_wr_ok   = coef_we && ({1'b0, coef_ch} < NCH_L) && ({1'b0, coef_tap} < NT_L);
  assign w_swap    = in_valid && (r_pend || coef_swap);
  assign w_shamt   = (null_div > SH_MAX) ? SH_MAX : null_div;
  assign w_shifted = r_node[1] >>> w_shamt;
  assign w_hi      = (w_shifted > SAT_MAX);
  assign w_lo      = (w_shifted < SAT_MIN);
  assign w_sat_val = w_hi ? SAT_MAX[D_WIDTH-1:0] : (w_lo ? SAT_MIN[D_WIDTH-1:0] : w_shifted[D_WIDTH-1:0]);

  always_comb begin
    w_val = '{default: '0};
    for (int i = 2; i < LEAVES; i++) begin
      w_val[i] = r_node[i];
    end
    for (int p = 0; p < LEAVES; p++) begin
      if (p < NPROD) begin
        w_val[LEAVES + p] = SUM_W'(r_prod[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NT; k++) begin
          r_dly[c][k]     <= '0;
          r_coef[0][c][k] <= '0;
          r_coef[1][c][k] <= '0;
        end
      end
      r_vp        <= '0;
      r_active    <= 1'b0;
      r_pend      <= 1'b0;
      r_swap_done <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_cnt   <= '0;
    end else begin
      if (in_valid) begin
        for (int c = 0; c < NCH; c++) begin
          r_dly[c][0] <= $signed(in_data[c*D_WIDTH +: D_WIDTH]);
          for (int k = 1; k < NT; k++) begin
            r_dly[c][k] <= r_dly[c][k-1];
          end
        end
      end
      // The write targets the bank that is shadow before any swap in this cycle.
      if (w_wr_ok) begin
        r_coef[~r_active][coef_ch][coef_tap] <= coef_data;
      end
      if (w_swap) begin
        r_active    <= ~r_active;
        r_pend      <= 1'b0;
        r_swap_done <= 1'b1;
      end else begin
        r_swap_done <= 1'b0;
        if (coef_swap) begin
          r_pend <= 1'b1;
        end
      end
      r_vp        <= {r_vp[LVL:0], in_valid & ce};
      r_out_valid <= r_vp[LVL+1];
      if (r_vp[LVL+1]) begin
        r_out_data <= w_sat_val;
      end
      if (sat_clr) begin
        r_sat_cnt <= '0;
      end else if (r_vp[LVL+1] && (w_hi || w_lo) && (r_sat_cnt != CNT_MAX)) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NPROD; p++) begin
        r_prod[p] <= '0;
      end
      for (int i = 1; i < LEAVES; i++) begin
        r_node[i] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NT; k++) begin
          r_prod[c*NT + k] <= PROD_W'(r_dly[c][k]) *
                              (coef_mirr ? PROD_W'(r_coef[r_active][c][NT-1-k])
                                         : PROD_W'(r_coef[r_active][c][k]));
        end
      end
      for (int i = 1; i < LEAVES; i++) begin
        r_node[i] <= w_val[2*i] + w_val[2*i+1];
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign active_bank = r_active;
  assign swap_done   = r_swap_done;
  assign sat_cnt     = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_null_former_dbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_null_former_dbuf                                             |
// | Brief    : Directed self-checking bench for null_former_dbuf (defaults).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_null_former_dbuf;

  localparam int NCH  = 4;
  localparam int DW   = 12;
  localparam int CW   = 16;
  localparam int CNTW = 16;
  localparam int LAT  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic              ce = 1'b1;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_ch = '0;
  logic [2:0]        coef_tap = '0;
  logic [CW-1:0]     coef_data = '0;
  logic              coef_swap = 1'b0;
  logic              coef_mirr = 1'b0;
  logic [7:0]        null_div = '0;
  logic              sat_clr = 1'b0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              active_bank;
  logic              swap_done;
  logic [CNTW-1:0]   sat_cnt;

  null_former_dbuf u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ce(ce),
    .coef_we(coef_we), .coef_ch(coef_ch), .coef_tap(coef_tap), .coef_data(coef_data),
    .coef_swap(coef_swap), .coef_mirr(coef_mirr), .null_div(null_div), .sat_clr(sat_clr),
    .out_valid(out_valid), .out_data(out_data), .active_bank(active_bank),
    .swap_done(swap_done), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_swd = 0;
  int q_dat[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_dat.push_back(int'($signed(out_data)));
      q_cyc.push_back(cyc);
    end
    if (swap_done) n_swd = n_swd + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qd(input int i);
    return (i < q_dat.size()) ? q_dat[i] : -999999;
  endfunction

  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -999999;
  endfunction

  function automatic logic [NCH*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int ch, input int tap, input int v);
    coef_we   = 1'b1;
    coef_ch   = 2'(ch);
    coef_tap  = 3'(tap);
    coef_data = 16'(v);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic pulse_swap();
    coef_swap = 1'b1;
    step();
    coef_swap = 1'b0;
  endtask

  task automatic send(input logic [NCH*DW-1:0] d, input logic c);
    in_data  = d;
    in_valid = 1'b1;
    ce       = c;
    step();
    in_valid = 1'b0;
    ce       = 1'b1;
  endtask

  task automatic drain();
    repeat (LAT + 4) step();
  endtask

  task automatic run_impulse(input logic mirr);
    int qb, sb, c0;
    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(0, k, k + 1);
    pulse_swap();
    coef_mirr = mirr;
    qb = q_dat.size();
    sb = n_swd;
    c0 = cyc;
    send(pk(1, 0, 0, 0), 1'b1);
    for (int i = 0; i < 7; i++) send(pk(0, 0, 0, 0), 1'b1);
    drain();
    for (int i = 0; i < 8; i++)
      check(mirr ? "mirror_out" : "impulse_out", qd(qb + i), mirr ? 8 - i : i + 1);
    check("impulse_latency", qc(qb), c0 + LAT);
    check("impulse_count", q_dat.size() - qb, 8);
    check("swap_done_once", n_swd - sb, 1);
    check("active_bank_1", int'(active_bank), 1);
    coef_mirr = 1'b0;
  endtask

  initial begin
    int qb, c0;

    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_swap_done", int'(swap_done), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    check("rst_active_bank", int'(active_bank), 0);

    run_impulse(1'b0);
    run_impulse(1'b1);

    // Saturation: 4 * 2047 * 16 = 131008
    do_reset();
    for (int c = 0; c < NCH; c++) wr_coef(c, 0, 16);
    pulse_swap();
    qb = q_dat.size();
    repeat (3) send(pk(2047, 2047, 2047, 2047), 1'b1);
    drain();
    for (int i = 0; i < 3; i++) check("sat_pos_out", qd(qb + i), 2047);
    check("sat_pos_cnt", int'(sat_cnt), 3);
    null_div = 8'd6;
    qb = q_dat.size();
    repeat (2) send(pk(2047, 2047, 2047, 2047), 1'b1);
    drain();
    check("shift6_out", qd(qb), 2047);
    check("shift6_cnt", int'(sat_cnt), 3);
    null_div = 8'd0;
    qb = q_dat.size();
    repeat (2) send(pk(-2048, -2048, -2048, -2048), 1'b1);
    drain();
    check("sat_neg_out", qd(qb + 1), -2048);
    check("sat_neg_cnt", int'(sat_cnt), 5);

    // Bank isolation
    do_reset();
    wr_coef(0, 0, 3);
    pulse_swap();
    qb = q_dat.size();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        coef_we = 1'b1; coef_ch = 2'd0; coef_tap = 3'd0; coef_data = 16'd5;
      end
      send(pk(100, 0, 0, 0), 1'b1);
      coef_we = 1'b0;
    end
    drain();
    for (int i = 0; i < 10; i++) check("iso_out", qd(qb + i), 300);
    pulse_swap();
    repeat (3) step();
    check("swap_wait_bank", int'(active_bank), 1);
    qb = q_dat.size();
    c0 = cyc;
    send(pk(100, 0, 0, 0), 1'b1);
    check("swap_gap_bank", int'(active_bank), 0);
    drain();
    check("newbank_out", qd(qb), 500);
    check("newbank_latency", qc(qb), c0 + LAT);

    // ce gaps
    qb = q_dat.size();
    for (int i = 0; i < 10; i++) send(pk(100, 0, 0, 0), (i >= 3 && i <= 5) ? 1'b0 : 1'b1);
    drain();
    check("ce_count", q_dat.size() - qb, 7);
    check("ce_out", qd(qb + 6), 500);

    // Reset with samples in flight
    qb = q_dat.size();
    coef_swap = 1'b1;
    send(pk(100, 0, 0, 0), 1'b1);
    coef_swap = 1'b0;
    repeat (4) send(pk(100, 0, 0, 0), 1'b1);
    check("pre_rst_bank", int'(active_bank), 1);
    do_reset();
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_bank", int'(active_bank), 0);
    check("mid_rst_swap_done", int'(swap_done), 0);
    drain();
    check("flush_count", q_dat.size() - qb, 0);

    // Counter limits
    do_reset();
    for (int c = 0; c < NCH; c++) wr_coef(c, 0, 16);
    pulse_swap();
    for (int i = 0; i < 65540; i++) send(pk(2047, 2047, 2047, 2047), 1'b1);
    drain();
    check("cnt_sticky", int'(sat_cnt), 65535);
    qb = q_dat.size();
    send(pk(2047, 2047, 2047, 2047), 1'b1);
    repeat (LAT - 2) step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("clr_with_valid", int'(out_valid), 1);
    check("clr_priority", int'(sat_cnt), 0);
    drain();
    check("clr_out_count", q_dat.size() - qb, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/null_former_dbuf.md
Name: null_former_dbuf

Overview:
- Parametrised next-generation CRPA null-forming channel.
- Each of NCH antenna inputs passes through an NT-tap real FIR; all taps of all channels are summed in one registered adder tree.
- The sum is arithmetically right-shifted, saturated to D_WIDTH and output.
- Adds double-buffered coefficient banks with sample-aligned swap, and a saturation event counter.

Parameters:
- NCH, 4, number of antenna channels (>=1)
- NT, 8, taps per channel FIR (>=2)
- D_WIDTH, 12, signed sample width, input and output
- C_WIDTH, 16, signed coefficient width
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample strobe for all channels
- in_data  in  NCH*D_WIDTH  channel ch occupies bits [ch*D_WIDTH +: D_WIDTH], signed
- ce  in  1  output enable, sampled with in_valid
- coef_we  in  1  shadow-bank write strobe
- coef_ch  in  clog2(NCH) (min 1)  channel index of write
- coef_tap  in  clog2(NT)  tap index of write
- coef_data  in  C_WIDTH  signed coefficient
- coef_swap  in  1  pulse: request bank swap
- coef_mirr  in  1  1 = tap k uses coefficient NT-1-k
- null_div  in  8  arithmetic right shift of the sum
- sat_clr  in  1  clear saturation counter
- out_valid  out  1  output strobe
- out_data  out  D_WIDTH  signed null-formed sample
- active_bank  out  1  index of the bank in use
- swap_done  out  1  one-cycle pulse after a swap
- sat_cnt  out  CNT_WIDTH  saturated-output count, sticky at max

Behaviour:
- Reset values: all delay lines 0; both coefficient banks 0; active_bank 0; swap pending 0; valid pipeline 0.
- Reset values, outputs: out_valid 0, out_data 0, swap_done 0, sat_cnt 0.
- Reset mid-stream flushes the pipeline: no out_valid from samples accepted before reset.
- Widths: PROD_W = D_WIDTH + C_WIDTH. SUM_W = PROD_W + clog2(NCH*NT).
- Pipeline stage 1 (delay line): on in_valid, each channel delay line shifts in the new sample (tap 0 = newest). Without in_valid it holds.
- Pipeline stage 2 (products): NCH*NT signed products, registered, using the active bank and coef_mirr as sampled in that cycle.
- Pipeline stage 3 (adder tree): clog2(NCH*NT) registered levels. Missing leaves are zero.
- Pipeline stage 4 (output): shift = null_div, clamped to SUM_W-1, arithmetic right shift (truncate toward -inf). Saturate to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
- Latency: LAT = 3 + clog2(NCH*NT) cycles, from in_valid at cycle t to out_valid at t+LAT. Defaults give LAT = 8. Fully pipelined, one sample per cycle.
- The valid pipeline carries in_valid & ce. Samples accepted with ce=0 still enter the delay line but produce no out_valid. out_data holds between strobes.
- Coefficient writes: coef_we writes coef_data to bank !active_bank at [coef_ch][coef_tap]. Writes with out-of-range indices are ignored. The active bank is never written.
- Swap pending: coef_swap sets pending; further coef_swap while pending has no effect.
- Swap execution: at the first cycle with pending & in_valid, active_bank toggles and pending clears. That sample and all later ones use the new bank. swap_done pulses the next cycle.
- If coef_swap and in_valid coincide, the swap happens in that same cycle.
- A coef_we in the swap cycle writes the pre-swap shadow bank, which becomes active.
- Saturation counter: sat_cnt increments on each out_valid whose value was clipped, and holds at 2^CNT_WIDTH-1.
- sat_clr has priority: if clear and increment coincide, the result is 0.

Test Plan:
- Impulse response: bank 1 ch0 taps = 1..8, others 0; swap; null_div=0; ch0 impulse 1, then 7 zeros, all channels in_valid every cycle -> out_data 1,2,...,8, first value 8 cycles after the impulse; swap_done once; active_bank=1.
- Mirror: same as impulse response with coef_mirr=1 -> 8,7,...,1.
- Saturation: all channels 2047, tap0 coef 16 on every channel, null_div=0 -> sum 131008, out 2047, sat_cnt +1 per sample. Same with null_div=6 -> out 2047 exactly, sat_cnt unchanged. Inputs -2048, null_div=0 -> out -2048, counted.
- Bank isolation: stream constant 100 on ch0; load a new shadow bank; output unchanged. Pulse coef_swap during an in_valid gap -> no change until the next in_valid, after which the new bank's sum appears exactly LAT later.
- ce and reset: ce=0 for 3 samples -> exactly 3 missing out_valid. Assert rst while 5 samples are in flight -> no out_valid for them; all outputs 0; active_bank 0.
- Counter limits: force 65536 saturating samples -> sat_cnt 65535 held. Assert sat_clr together with a saturating out_valid -> sat_cnt 0.
